result_line_streamer: RTL

- Read-out end of the line interface. The loader pushes 64 lines of 25 bits into the design indexed by a 6-bit count; this block returns the processed 64-line result the same way.
- The Datapath writes result lines into an internal 64x25 buffer. On start, the block streams the lines out in index order (0..63) over a valid/ready handshake, each tagged with its index, then pulses done.
- Sits between Datapath and the output sink (file dumper or next stage).

---
 rtl/result_line_streamer_if.sv | 42 ++++
 rtl/result_line_streamer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/result_line_streamer_if.sv
// Bus bundle for result_line_streamer: buffer write port, start, output stream and status.
// Optional LINE_PARITY_EN adds out_parity and par_err.
interface result_line_streamer_if #(
    parameter int LINE_W = 25,
    parameter int ADDR_W = 6
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [LINE_W-1:0] wr_data;
    logic              start;
    logic [LINE_W-1:0] out_line;
    logic [ADDR_W-1:0] out_idx;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              wr_blocked;
`ifdef LINE_PARITY_EN
    logic              out_parity;
    logic              par_err;

    modport master (
        output wr_en, wr_addr, wr_data, start, out_ready,
        input  out_line, out_idx, out_valid, busy, done, wr_blocked, out_parity, par_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, out_ready,
        output out_line, out_idx, out_valid, busy, done, wr_blocked, out_parity, par_err
    );
`else
    modport master (
        output wr_en, wr_addr, wr_data, start, out_ready,
        input  out_line, out_idx, out_valid, busy, done, wr_blocked
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, out_ready,
        output out_line, out_idx, out_valid, busy, done, wr_blocked
    );
`endif
endinterface

// File: rtl/result_line_streamer.sv
// Buffers DEPTH result lines from the Datapath and streams them out in index order over valid/ready.
// Optional LINE_PARITY_EN: per-entry stored parity, out_parity output and sticky par_err.
module result_line_streamer #(
    parameter int LINE_W = 25,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    result_line_streamer_if.slave io_bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [LINE_W-1:0] r_buf [DEPTH];
    logic [LINE_W-1:0] r_outLine;
    logic [ADDR_W-1:0] r_outIdx;
    logic              r_outValid;
    logic              r_wrBlocked;

    logic              w_writeOk;
    logic              w_writeBlocked;
    logic              w_handshake;
    logic              w_lastIdx;
    logic [LINE_W-1:0] w_fetchLine;

`ifdef LINE_PARITY_EN
    logic              r_bufPar [DEPTH];
    logic              r_outParity;
    logic              r_parErr;
    logic              w_fetchPar;
`endif

    // The buffer only accepts writes while no stream is reading it.
    assign w_writeOk      = io_bus.wr_en && ((r_state == S_IDLE) || (r_state == S_FIN));
    assign w_writeBlocked = io_bus.wr_en && ((r_state == S_FETCH) || (r_state == S_SEND));
    assign w_handshake    = (r_state == S_SEND) && r_outValid && io_bus.out_ready;
    assign w_lastIdx      = (r_idx == ADDR_W'(DEPTH - 1));
    assign w_fetchLine    = r_buf[r_idx];
`ifdef LINE_PARITY_EN
    assign w_fetchPar     = ^w_fetchLine;
`endif

    // Buffer storage is deliberately left out of reset so results survive an aborted stream.
    always_ff @(posedge i_clk) begin
        if (i_rst && w_writeOk) begin
            r_buf[io_bus.wr_addr] <= io_bus.wr_data;
`ifdef LINE_PARITY_EN
            r_bufPar[io_bus.wr_addr] <= ^io_bus.wr_data;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_outLine   <= '0;
            r_outIdx    <= '0;
            r_outValid  <= 1'b0;
            r_wrBlocked <= 1'b0;
`ifdef LINE_PARITY_EN
            r_outParity <= 1'b0;
            r_parErr    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_state     <= S_FETCH;
                        r_idx       <= '0;
                        r_wrBlocked <= 1'b0;
`ifdef LINE_PARITY_EN
                        r_parErr    <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    r_outLine  <= w_fetchLine;
                    r_outIdx   <= r_idx;
                    r_outValid <= 1'b1;
                    r_state    <= S_SEND;
`ifdef LINE_PARITY_EN
                    r_outParity <= w_fetchPar;
                    if (r_bufPar[r_idx] != w_fetchPar) begin
                        r_parErr <= 1'b1;
                    end
`endif
                end
                S_SEND: begin
                    // out_line/out_idx stay untouched here, so they hold until the sink accepts.
                    if (w_handshake) begin
                        r_outValid <= 1'b0;
                        if (w_lastIdx) begin
                            r_state <= S_FIN;
                        end else begin
                            r_idx   <= r_idx + ADDR_W'(1);
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_writeBlocked) begin
                r_wrBlocked <= 1'b1;
            end
        end
    end

    assign io_bus.out_line   = r_outLine;
    assign io_bus.out_idx    = r_outIdx;
    assign io_bus.out_valid  = r_outValid;
    assign io_bus.busy       = (r_state == S_FETCH) || (r_state == S_SEND);
    assign io_bus.done       = (r_state == S_FIN);
    assign io_bus.wr_blocked = r_wrBlocked;
`ifdef LINE_PARITY_EN
    assign io_bus.out_parity = r_outParity;
    assign io_bus.par_err    = r_parErr;
`endif

endmodule
